// File: rtl/rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int RR_N_DEF        = 4;
  localparam int RR_MAX_HOLD_DEF = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Latency: n/a (wires only); the grant side is driven from arbiter registers.
// Backpressure: level-sensitive req; a requester holds req until it sees its gnt bit.
interface rr_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N = RR_N_DEF
) ();

  logic [N-1:0]          req;
  logic [N-1:0]          gnt;
  logic [idx_w(N)-1:0]   gnt_idx;
  logic                  gnt_valid;
  logic                  preempt;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input preempt);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output preempt);

endinterface

// File: rtl/rr_arbiter_rps.sv
// Rotating priority selector: first set req bit scanning from last_idx+1 upward, mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output simply tracks req and last_idx.
module rps_n
  import rr_arb_pkg::*;
#(
  parameter int N  = RR_N_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] sel_idx_o,
  output logic          sel_valid_o
);

  // Scan N candidates starting just past the last owner; the last owner itself is checked last.
  always_comb begin
    sel_o       = '0;
    sel_idx_o   = '0;
    sel_valid_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int              c;
      logic [IW-1:0]   ci;
      c = int'(last_idx_i) + i;
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!sel_valid_o && req_i[ci]) begin
        sel_o[ci]   = 1'b1;
        sel_idx_o   = ci;
        sel_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant; optional hold limit under RR_ARB_TIMEOUT_EN.
// Latency: grant visible the cycle after req is sampled in idle; one bubble cycle after every release.
// Backpressure: owner keeps the grant while its req stays high (or until the hold limit under contention).
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = RR_N_DEF,
  parameter int MAX_HOLD = RR_MAX_HOLD_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  rr_arbiter_if.slave  arb
);

  localparam int IW = idx_w(N);

  // Reject configurations outside the supported range at elaboration.
  if (N < 2 || N > 8 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("rr_arbiter: unsupported N=%0d / MAX_HOLD=%0d", N, MAX_HOLD);
  end

  arb_state_t     state_q;
  logic [N-1:0]   gnt_q;
  logic [IW-1:0]  gnt_idx_q;
  logic [IW-1:0]  last_idx_q;

  logic [N-1:0]   sel;
  logic [IW-1:0]  sel_idx;
  logic           sel_valid;

  rps_n #(.N(N), .IW(IW)) u_rps (
    .req_i       (arb.req),
    .last_idx_i  (last_idx_q),
    .sel_o       (sel),
    .sel_idx_o   (sel_idx),
    .sel_valid_o (sel_valid)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt_q;
  logic          preempt_q;
  logic          contended;

  // Someone other than the current owner is asking for the resource.
  assign contended = |(arb.req & ~gnt_q);

  // Arbitration FSM with hold-limit preemption; all outputs registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= IW'(N - 1);
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (sel_valid) begin
            gnt_q      <= sel;
            gnt_idx_q  <= sel_idx;
            hold_cnt_q <= '0;
            state_q    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!arb.req[gnt_idx_q]) begin
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= gnt_idx_q;
            state_q    <= ARB_IDLE;
          end else if (hold_cnt_q == HOLD_LAST && contended) begin
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= gnt_idx_q;
            preempt_q  <= 1'b1;
            state_q    <= ARB_IDLE;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign arb.preempt = preempt_q;
`else
  // Arbitration FSM without hold limit: owner keeps the grant until it drops req.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= IW'(N - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (sel_valid) begin
            gnt_q     <= sel;
            gnt_idx_q <= sel_idx;
            state_q   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!arb.req[gnt_idx_q]) begin
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= gnt_idx_q;
            state_q    <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign arb.preempt = 1'b0;
`endif

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=4) with a queue of expected per-cycle outputs.
// Latency: each step drives req, expects the post-edge outputs one edge later.
// Backpressure: n/a.
module tb_rr_arbiter;

  logic clock;
  logic reset_n;

  rr_arbiter_if #(.N(4)) bus ();

  rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .arb     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] gnt;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];
  int   compared = 0;
  int   failed   = 0;

  function automatic logic [1:0] exp_idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] expv);
    compared++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      compared++;
      failed++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      cmp(tag, "gnt",       bus.gnt,                 e.gnt);
      cmp(tag, "gnt_idx",   {2'b00, bus.gnt_idx},    {2'b00, exp_idx(e.gnt)});
      cmp(tag, "gnt_valid", {3'b000, bus.gnt_valid}, {3'b000, |e.gnt});
      cmp(tag, "preempt",   {3'b000, bus.preempt},   {3'b000, e.pre});
    end
  endtask

  // Drive req, expect (g, p) on outputs just after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic p, input string tag);
    exp_t e;
    bus.req = r;
    e.gnt = g;
    e.pre = p;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    pop_check(tag);
  endtask

  task automatic check_now(input logic [3:0] g, input logic p, input string tag);
    exp_t e;
    e.gnt = g;
    e.pre = p;
    sb_q.push_back(e);
    pop_check(tag);
  endtask

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.req = 4'b1111;
    #1;
    check_now(4'b0000, 1'b0, "rst_t0");
    step(4'b1111, 4'b0000, 1'b0, "rst_a");
    step(4'b1111, 4'b0000, 1'b0, "rst_b");

    reset_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b0, "idle");

    // Requesters 1 and 2; 1 wins from reset priority, holds 3 cycles, bubble, then 2.
    step(4'b0110, 4'b0010, 1'b0, "g1_a");
    step(4'b0110, 4'b0010, 1'b0, "g1_b");
    step(4'b0110, 4'b0010, 1'b0, "g1_c");
    step(4'b0100, 4'b0000, 1'b0, "g1_bubble");
    step(4'b0100, 4'b0100, 1'b0, "g2_a");
    step(4'b0100, 4'b0100, 1'b0, "g2_b");

    // Asynchronous reset mid-tenure clears the grant without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check_now(4'b0000, 1'b0, "rst_async");
    #1;
    reset_n = 1'b1;

    // All requesting; each owner drops for one cycle after two grant cycles.
    step(4'b1111, 4'b0001, 1'b0, "rr0_a");
    step(4'b1111, 4'b0001, 1'b0, "rr0_b");
    step(4'b1110, 4'b0000, 1'b0, "rr0_bub");
    step(4'b1111, 4'b0010, 1'b0, "rr1_a");
    step(4'b1111, 4'b0010, 1'b0, "rr1_b");
    step(4'b1101, 4'b0000, 1'b0, "rr1_bub");
    step(4'b1111, 4'b0100, 1'b0, "rr2_a");
    step(4'b1111, 4'b0100, 1'b0, "rr2_b");
    step(4'b1011, 4'b0000, 1'b0, "rr2_bub");
    step(4'b1111, 4'b1000, 1'b0, "rr3_a");
    step(4'b1111, 4'b1000, 1'b0, "rr3_b");
    step(4'b0111, 4'b0000, 1'b0, "rr3_bub");
    step(4'b1111, 4'b0001, 1'b0, "rr0_again");

    // Requesters 0 and 1 held; owner 0 has already had one grant cycle.
`ifdef RR_ARB_TIMEOUT_EN
    step(4'b0011, 4'b0001, 1'b0, "to0_2");
    step(4'b0011, 4'b0001, 1'b0, "to0_3");
    step(4'b0011, 4'b0001, 1'b0, "to0_4");
    step(4'b0011, 4'b0000, 1'b1, "to0_pre");
    step(4'b0011, 4'b0010, 1'b0, "to1_1");
    step(4'b0011, 4'b0010, 1'b0, "to1_2");
    step(4'b0011, 4'b0010, 1'b0, "to1_3");
    step(4'b0011, 4'b0010, 1'b0, "to1_4");
    step(4'b0011, 4'b0000, 1'b1, "to1_pre");
    step(4'b0011, 4'b0001, 1'b0, "to0_again");
`else
    for (int i = 0; i < 10; i++) step(4'b0011, 4'b0001, 1'b0, "hold0");
`endif

    // Single requester 3: owner 0 releases, 3 granted, drop one cycle, regranted after bubble.
    step(4'b1000, 4'b0000, 1'b0, "s_rel0");
    step(4'b1000, 4'b1000, 1'b0, "s3_a");
    step(4'b0000, 4'b0000, 1'b0, "s3_drop");
    step(4'b1000, 4'b1000, 1'b0, "s3_regrant");
    step(4'b0000, 4'b0000, 1'b0, "s3_end");

    if (sb_q.size() != 0) begin
      compared++;
      failed++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
